// File: rtl/genie_pipe_pkg.sv
// genie_pipe_pkg: sizing helpers shared by the GENIE pipe blocks.
package genie_pipe_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/genie_pipe_fifo_mem.sv
// genie_pipe_fifo_mem: WIDTH x DEPTH array, sync write, async read.
module genie_pipe_fifo_mem #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int MLAB  = 0
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    generate
        if (MLAB != 0) begin : g_mlab
            (* ramstyle = "no_rw_check,MLAB" *)
            logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_we) mem[i_waddr] <= i_wdata;
            end

            assign o_rdata = mem[i_raddr];
        end else begin : g_reg
            logic [WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_we) mem[i_waddr] <= i_wdata;
            end

            assign o_rdata = mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/genie_pipe_fifo.sv
// genie_pipe_fifo: FWFT valid/ready FIFO with count, almost-full, flush.
// High-water mark register enabled by GENIE_PIPE_FIFO_STATS_EN.
module genie_pipe_fifo
    import genie_pipe_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter int MLAB         = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_almost_full,
    output logic [$clog2(DEPTH):0] o_max_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] AF = PW'(AFULL_THRESH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
            $error("genie_pipe_fifo: DEPTH must be a power of two >= 2");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
            $error("genie_pipe_fifo: AFULL_THRESH must be in 1..DEPTH");
        end
    endgenerate

    logic [PW-1:0] wrptr, rdptr;
    logic [PW-1:0] wr_next, rd_next;
    logic          empty, full, push, pop;

    assign empty = (wrptr == rdptr);
    assign full  = (wrptr[AW-1:0] == rdptr[AW-1:0]) &&
                   (wrptr[AW] != rdptr[AW]);

    assign o_ready       = !full && !i_flush && !i_reset;
    assign o_valid       = !empty;
    assign o_count       = wrptr - rdptr;
    assign o_almost_full = (o_count >= AF);

    assign push = i_valid && o_ready;
    // A flush voids any pop offered in the same cycle.
    assign pop  = o_valid && i_ready && !i_flush;

    always_comb begin
        wr_next = wrptr;
        rd_next = rdptr;
        if (i_reset) begin
            wr_next = '0;
            rd_next = '0;
        end else if (i_flush) begin
            rd_next = wrptr;
        end else begin
            if (push) wr_next = wrptr + 1'b1;
            if (pop)  rd_next = rdptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        wrptr <= wr_next;
        rdptr <= rd_next;
    end

    genie_pipe_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .MLAB  (MLAB)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wrptr[AW-1:0]),
        .i_wdata (i_data),
        .i_raddr (rdptr[AW-1:0]),
        .o_rdata (o_data)
    );

`ifdef GENIE_PIPE_FIFO_STATS_EN
    logic [PW-1:0] count_next;
    logic [PW-1:0] max_q;

    assign count_next = wr_next - rd_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            max_q <= '0;
        end else if (count_next > max_q) begin
            max_q <= count_next;
        end
    end

    assign o_max_count = max_q;
`else
    assign o_max_count = '0;
`endif

endmodule
